// File: rtl/io_sw_conditioner.sv
// Purpose: synchronise and debounce board slide switches; emit edge pulses and sticky events.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES clk_i edges from raw change to sw_o update.
// Backpressure: none; sw_o is sampled every cycle and events are held until cleared.
module io_sw_conditioner #(
  parameter int WIDTH           = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] sw_raw_i,
  output logic [WIDTH-1:0] sw_o,
  output logic [WIDTH-1:0] sw_rise_o,
  output logic [WIDTH-1:0] sw_fall_o,
  output logic [WIDTH-1:0] sw_event_o,
  input  logic [WIDTH-1:0] event_clr_i,
  output logic             event_pending_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [CW-1:0]    cnt_d  [WIDTH];
  logic [WIDTH-1:0] smp;
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] sw_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] event_q;

  assign smp = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= sw_raw_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // A bit is accepted on the sample that would take its count past CNT_MAX.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (smp[i] != sw_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          accept[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      sw_q    <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      event_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      sw_q    <= sw_q ^ accept;
      rise_q  <= accept & smp;
      fall_q  <= accept & ~smp;
      // New transitions take priority over a same-cycle software clear.
      event_q <= accept | (event_q & ~event_clr_i);
    end
  end

  assign sw_o            = sw_q;
  assign sw_rise_o       = rise_q;
  assign sw_fall_o       = fall_q;
  assign sw_event_o      = event_q;
  assign event_pending_o = |event_q;

endmodule
